ps2_key_receiver: RTL and testbench

Parametrised PS/2 keyboard receiver that replaces the single-byte, fixed-rate decoder with a configurable-rate, filtered, framed receiver. Samples the open-collector PS2_CLK/PS2_DATA pair on a divided tick, validates 11-bit frames, folds E0 (extended) and F0 (break) prefixes into complete key events, and queues them in a FIFO with a valid/ready handshake. It sits between the keyboard pins and game logic (ship movement, fire), so no key press is lost to single-cycle pulses.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_event_fifo.sv | 68 ++++++
 rtl/ps2_key_receiver.sv | 193 +++++++++++++++++++
 tb/tb_ps2_key_receiver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared constants, event record and frame-check helper for the
//             PS/2 keyboard receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

   // Prefix bytes folded into the following scan code
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Scan codes used by the game logic
   localparam logic [7:0] PS2_KEY_UP    = 8'h75;
   localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;
   localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
   localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
   localparam logic [7:0] PS2_KEY_SPACE = 8'h29;

   // Queued key event: {ext, brk, code}
   localparam int PS2_EVT_W = 10;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } frame_state_e;

   // Frame layout after LSB-first shifting: [0]=start, [8:1]=data,
   // [9]=parity, [10]=stop. Data plus parity must carry an odd number of ones.
   function automatic logic frame_ok(input logic [10:0] f);
      return (!f[0]) && f[10] && (^f[9:1]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_event_fifo
//  Purpose  : Synchronous FIFO with first-word-fall-through head, push-while-
//             full-with-pop acceptance and a sticky overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_event_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             full, pop_ok, push_ok;

   // Occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == (AW+1)'(DEPTH));
      pop_ok    = pop && !empty;
      push_ok   = push && (!full || pop_ok);
      wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      ovf_d     = ovf_q | (push && !push_ok);
      head_data = empty ? '0 : mem_q[rd_ptr_q];
      overflow  = ovf_q;
   end

   // Pointer, count and overflow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array; contents are qualified by count, so no reset is needed
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_key_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_receiver
//  Purpose  : PS/2 keyboard receiver: pin synchroniser, sample tick, glitch
//             filter, 11-bit frame FSM, E0/F0 prefix folding and event FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_receiver #(
   parameter int CLK_DIV       = 250,
   parameter int FILTER_LEN    = 3,
   parameter int TIMEOUT_TICKS = 4000,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic       EVT_VALID,
   input  logic       EVT_READY,
   output logic [7:0] EVT_CODE,
   output logic       EVT_EXT,
   output logic       EVT_BREAK,
   output logic       FRAME_ERR,
   output logic       OVERFLOW
);
   import ps2_pkg::*;

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int RUN_W = $clog2(FILTER_LEN + 1);
   localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

   logic [1:0]       sclk_q, sclk_d, sdat_q, sdat_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             fclk_q, fclk_d;
   logic             tick, strobe, bit_in;

   frame_state_e     state_q, state_d;
   logic [3:0]       nbits_q, nbits_d;
   logic [10:0]      shreg_q, shreg_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             done_q, done_d, abort_q, abort_d;
   logic             ext_q, ext_d, brk_q, brk_d;

   logic             push, fifo_empty;
   ps2_evt_t         push_evt, head_evt;

   // Synchroniser, sample tick and clock filter; strobe marks a filtered falling edge
   always_comb begin
      sclk_d = {sclk_q[0], PS2_CLK};
      sdat_d = {sdat_q[0], PS2_DATA};
      tick   = (div_q == DIV_W'(CLK_DIV - 1));
      div_d  = tick ? '0 : div_q + 1'b1;
      bit_in = sdat_q[1];
      run_d  = run_q;
      fclk_d = fclk_q;
      strobe = 1'b0;
      if (tick) begin
         if (sclk_q[1] == fclk_q) begin
            run_d = '0;
         end else if (int'(run_q) + 1 >= FILTER_LEN) begin
            run_d  = '0;
            fclk_d = sclk_q[1];
            strobe = fclk_q;
         end else begin
            run_d = run_q + 1'b1;
         end
      end
   end

   // Frame FSM: collects 11 bits LSB-first and aborts on an inter-bit timeout
   always_comb begin
      state_d = state_q;
      nbits_d = nbits_q;
      shreg_d = shreg_q;
      tmo_d   = tmo_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (strobe && !bit_in) begin
               state_d = ST_RECV;
               nbits_d = 4'd1;
               shreg_d = {bit_in, 10'b0};
            end
         end
         ST_RECV: begin
            if (strobe) begin
               shreg_d = {bit_in, shreg_q[10:1]};
               tmo_d   = '0;
               if (nbits_q == 4'd10) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                  nbits_d = '0;
               end else begin
                  nbits_d = nbits_q + 1'b1;
               end
            end else if (tick) begin
               if (int'(tmo_q) + 1 >= TIMEOUT_TICKS) begin
                  abort_d = 1'b1;
                  state_d = ST_IDLE;
                  nbits_d = '0;
                  tmo_d   = '0;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Prefix decoder: runs the cycle after a completed or aborted frame
   always_comb begin
      ext_d         = ext_q;
      brk_d         = brk_q;
      push          = 1'b0;
      FRAME_ERR     = 1'b0;
      push_evt.ext  = ext_q;
      push_evt.brk  = brk_q;
      push_evt.code = shreg_q[8:1];
      if (abort_q || (done_q && !frame_ok(shreg_q))) begin
         FRAME_ERR = 1'b1;
         ext_d     = 1'b0;
         brk_d     = 1'b0;
      end else if (done_q) begin
         if (shreg_q[8:1] == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (shreg_q[8:1] == PS2_BRK) begin
            brk_d = 1'b1;
         end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
   end

   // State registers for the front end, frame FSM and prefix flags
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         sclk_q  <= 2'b11;
         sdat_q  <= 2'b11;
         div_q   <= '0;
         run_q   <= '0;
         fclk_q  <= 1'b1;
         state_q <= ST_IDLE;
         nbits_q <= '0;
         shreg_q <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
      end else begin
         sclk_q  <= sclk_d;
         sdat_q  <= sdat_d;
         div_q   <= div_d;
         run_q   <= run_d;
         fclk_q  <= fclk_d;
         state_q <= state_d;
         nbits_q <= nbits_d;
         shreg_q <= shreg_d;
         tmo_q   <= tmo_d;
         done_q  <= done_d;
         abort_q <= abort_d;
         ext_q   <= ext_d;
         brk_q   <= brk_d;
      end
   end

   ps2_event_fifo #(
      .WIDTH (PS2_EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RESETN),
      .push      (push),
      .push_data (push_evt),
      .pop       (EVT_READY),
      .head_data (head_evt),
      .empty     (fifo_empty),
      .overflow  (OVERFLOW)
   );

   assign EVT_VALID = !fifo_empty;
   assign EVT_CODE  = head_evt.code;
   assign EVT_EXT   = head_evt.ext;
   assign EVT_BREAK = head_evt.brk;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_receiver
//  Purpose  : Self-checking bench for ps2_key_receiver with an event-level
//             reference model (expected-event queue, prefix flags, error count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_receiver;
   import ps2_pkg::*;

   localparam int CLK_DIV       = 4;
   localparam int FILTER_LEN    = 3;
   localparam int TIMEOUT_TICKS = 50;
   localparam int FIFO_DEPTH    = 4;
   localparam int HALF          = 5;   // ticks per PS/2 clock half-period

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       evt_ready = 1'b0;
   logic       evt_valid, evt_ext, evt_brk, frame_err, overflow;
   logic [7:0] evt_code;

   always #5 clk = ~clk;

   ps2_key_receiver #(
      .CLK_DIV       (CLK_DIV),
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_TICKS (TIMEOUT_TICKS),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) dut (
      .CLK       (clk),
      .RESETN    (rst_n),
      .PS2_CLK   (ps2_clk),
      .PS2_DATA  (ps2_dat),
      .EVT_VALID (evt_valid),
      .EVT_READY (evt_ready),
      .EVT_CODE  (evt_code),
      .EVT_EXT   (evt_ext),
      .EVT_BREAK (evt_brk),
      .FRAME_ERR (frame_err),
      .OVERFLOW  (overflow)
   );

   int          tests = 0;
   int          fails = 0;
   logic [9:0]  exp_q[$];
   bit          m_ext = 0, m_brk = 0, exp_ovf = 0;
   int          exp_err = 0, got_err = 0, popped = 0;
   logic [9:0]  last_evt = '0;
   logic        prev_err = 1'b0;
   int          ready_mode = 0;    // 0: hold low, 1: hold high, 2: random

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: what the receiver must do with one whole frame
   task automatic model_frame(input logic [7:0] b, input bit bad);
      if (bad) begin
         exp_err++;
         m_ext = 0;
         m_brk = 0;
      end else if (b == PS2_EXT) begin
         m_ext = 1;
      end else if (b == PS2_BRK) begin
         m_brk = 1;
      end else begin
         if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1;
         else exp_q.push_back({m_ext, m_brk, b});
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   // Drive the first nbits of a frame onto the PS/2 pins
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         wait_cyc(2 * CLK_DIV);
         ps2_dat = f[i];
         wait_cyc((HALF - 2) * CLK_DIV);
         ps2_clk = 1'b0;
         wait_cyc(HALF * CLK_DIV);
         ps2_clk = 1'b1;
      end
      wait_cyc(HALF * CLK_DIV);
      ps2_dat = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b);
      model_frame(b, 0);
      send_frame(b, 0, 0, 11);
   endtask

   task automatic settle();
      int n = 0;
      while ((exp_q.size() != 0 || evt_valid) && n < 400) begin
         wait_cyc(1);
         n++;
      end
      check("drained_model", exp_q.size(), 0);
      check("drained_valid", evt_valid, 0);
      check("frame_err_count", got_err, exp_err);
      check("overflow", overflow, exp_ovf);
   endtask

   // EVT_READY driver, changes just after the active edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       evt_ready = 1'b0;
            1:       evt_ready = 1'b1;
            default: evt_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Compare process: head against model, handshake pops, FRAME_ERR width
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (frame_err) begin
               got_err++;
               check("frame_err_width", prev_err, 0);
            end
            prev_err = frame_err;
            if (evt_valid) begin
               check("evt_expected", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  check("evt_head", {evt_ext, evt_brk, evt_code}, exp_q[0]);
                  if (evt_ready) begin
                     last_evt = {evt_ext, evt_brk, evt_code};
                     void'(exp_q.pop_front());
                     popped++;
                  end
               end
            end
         end else begin
            prev_err = 1'b0;
         end
      end
   end

   initial begin
      #(800000);
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int         r;
      bit         bp, bs;

      // Reset state
      wait_cyc(5);
      check("rst_valid", evt_valid, 0);
      check("rst_code", evt_code, 0);
      check("rst_ext", evt_ext, 0);
      check("rst_brk", evt_brk, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      ready_mode = 1;
      wait_cyc(10 * CLK_DIV);

      // Plain make code
      send_good(8'h1C);
      settle();
      check("t1_evt", last_evt, 10'h01C);
      check("t1_count", popped, 1);
      check("t1_no_err", got_err, 0);

      // Extended break of arrow up
      send_good(PS2_EXT);
      send_good(PS2_BRK);
      send_good(PS2_KEY_UP);
      settle();
      check("t2_evt", last_evt, 10'h375);
      check("t2_count", popped, 2);

      // Bad parity discards byte and pending prefix
      send_good(PS2_EXT);
      model_frame(8'h1C, 1);
      send_frame(8'h1C, 1, 0, 11);
      settle();
      check("t3_err", got_err, 1);
      check("t3_count", popped, 2);
      send_good(8'h1B);
      settle();
      check("t3_evt", last_evt, 10'h01B);

      // Partial frame times out
      send_frame(8'h55, 0, 0, 5);
      wait_cyc(40 * CLK_DIV);
      check("t4_no_early_err", got_err, 1);
      wait_cyc(10 * CLK_DIV);
      exp_err++;
      check("t4_timeout_err", got_err, 2);
      send_good(PS2_KEY_SPACE);
      settle();
      check("t4_evt", last_evt, 10'h029);
      check("t4_count", popped, 4);

      // Randomised traffic with a stalling consumer
      ready_mode = 2;
      for (int i = 0; i < 30; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2)       b = PS2_EXT;
         else if (r == 2) b = PS2_BRK;
         else             b = 8'($urandom_range(0, 255));
         bp = ($urandom_range(0, 7) == 0);
         bs = ($urandom_range(0, 11) == 0);
         model_frame(b, bp | bs);
         send_frame(b, bp, bs, 11);
         ready_mode = 1;
         settle();
         ready_mode = 2;
      end

      // Overflow with consumer stalled
      ready_mode = 0;
      wait_cyc(4);
      r = popped;
      for (int i = 0; i < 5; i++) begin
         send_good(8'(8'h15 + i));
      end
      wait_cyc(4);
      check("t5_overflow", overflow, 1);
      check("t5_valid", evt_valid, 1);
      check("t5_head", evt_code, 8'h15);
      ready_mode = 1;
      settle();
      check("t5_count", popped - r, 4);
      check("t5_last", last_evt[7:0], 8'h18);
      check("t5_overflow_sticky", overflow, 1);

      // Short glitches on the clock with data low must not start a frame
      ps2_dat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ps2_clk = 1'b0;
         wait_cyc(((i % 2) + 1) * CLK_DIV);
         ps2_clk = 1'b1;
         wait_cyc(HALF * CLK_DIV);
      end
      ps2_dat = 1'b1;
      wait_cyc(60 * CLK_DIV);
      check("t6_no_err", got_err, exp_err);
      check("t6_no_evt", evt_valid, 0);

      // Reset in the middle of a frame
      send_frame(8'h6B, 0, 0, 7);
      wait_cyc(CLK_DIV);
      rst_n = 1'b0;
      exp_q.delete();
      m_ext = 0;
      m_brk = 0;
      exp_ovf = 0;
      wait_cyc(3);
      check("t7_valid", evt_valid, 0);
      check("t7_code", evt_code, 0);
      check("t7_ext", evt_ext, 0);
      check("t7_brk", evt_brk, 0);
      check("t7_frame_err", frame_err, 0);
      check("t7_overflow", overflow, 0);
      rst_n = 1'b1;
      wait_cyc(10 * CLK_DIV);
      send_good(PS2_KEY_RIGHT);
      settle();
      check("t7_evt", last_evt, 10'h074);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
